// File: rtl/csr_access_unit.sv
// Read-modify-write sequencer for CSRRW/RS/RC and their immediate forms on the M-mode CSR port.
// Optional build macro CSR_RO_TRAP_EN: write attempts to the read-only CSR space (addr[11:10]==2'b11) become illegal.
module csr_access_unit #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 12
) (
  input  logic              ctrl_clk,
  input  logic              ctrl_reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [4:0]        req_rs1_idx,
  input  logic [XLEN-1:0]   req_rs1_val,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_illegal,
  output logic [ADDR_W-1:0] csr_addr,
  output logic [XLEN-1:0]   csr_wdata,
  output logic              csr_wen,
  input  logic [XLEN-1:0]   csr_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t            state_r;
  logic [1:0]        op_r;
  logic [XLEN-1:0]   src_r;
  logic [XLEN-1:0]   old_r;
  logic              writes_r;
  logic              ro_trap_r;

  logic [XLEN-1:0]   src_s;
  logic              implemented_s;
  logic              illegal_s;
  logic              writes_s;
  logic              ro_trap_s;
  logic [XLEN-1:0]   new_s;

  assign req_ready = (state_r == IDLE) && !ctrl_reset;

  // Decode the presented request: operand source, legality and write intent.
  always_comb begin
    src_s         = req_funct3[2] ? {{(XLEN-5){1'b0}}, req_rs1_idx} : req_rs1_val;
    implemented_s = 1'b0;
    case (req_addr)
      ADDR_W'(12'h300), ADDR_W'(12'h301), ADDR_W'(12'h304), ADDR_W'(12'h305),
      ADDR_W'(12'h340), ADDR_W'(12'h341), ADDR_W'(12'h342), ADDR_W'(12'h343),
      ADDR_W'(12'h344), ADDR_W'(12'hF14): implemented_s = 1'b1;
      default:                            implemented_s = 1'b0;
    endcase
    illegal_s = (req_funct3[1:0] == 2'b00) || !implemented_s;
    // Set/clear with rs1 (or zimm) index zero is a pure read and never writes.
    writes_s  = (req_funct3[1:0] == 2'b01) || (req_rs1_idx != 5'd0);
`ifdef CSR_RO_TRAP_EN
    ro_trap_s = writes_s && (req_addr[ADDR_W-1:ADDR_W-2] == 2'b11);
`else
    ro_trap_s = 1'b0;
`endif
  end

  // New CSR value from the value read this cycle and the latched operand.
  always_comb begin
    case (op_r)
      2'b01:   new_s = src_r;
      2'b10:   new_s = csr_rdata | src_r;
      2'b11:   new_s = csr_rdata & ~src_r;
      default: new_s = csr_rdata;
    endcase
  end

  // Sequencer state, request latches and all registered outputs.
  always_ff @(posedge ctrl_clk) begin
    if (ctrl_reset) begin
      state_r     <= IDLE;
      op_r        <= 2'b00;
      src_r       <= '0;
      old_r       <= '0;
      writes_r    <= 1'b0;
      ro_trap_r   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_illegal <= 1'b0;
      rsp_rdata   <= '0;
      csr_addr    <= '0;
      csr_wdata   <= '0;
      csr_wen     <= 1'b0;
    end else begin
      csr_wen <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            op_r      <= req_funct3[1:0];
            src_r     <= src_s;
            csr_addr  <= req_addr;
            writes_r  <= writes_s;
            ro_trap_r <= ro_trap_s;
            if (illegal_s) begin
              state_r     <= RESP;
              rsp_valid   <= 1'b1;
              rsp_illegal <= 1'b1;
              rsp_rdata   <= '0;
            end else begin
              state_r <= READ;
            end
          end
        end
        READ: begin
          old_r     <= csr_rdata;
          csr_wdata <= new_s;
          csr_wen   <= writes_r && !ro_trap_r;
          state_r   <= WRITE;
        end
        WRITE: begin
          state_r     <= RESP;
          rsp_valid   <= 1'b1;
          rsp_illegal <= ro_trap_r;
          rsp_rdata   <= ro_trap_r ? '0 : old_r;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule
